// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational 3-bit-function ALU between two
// requesters. Round-robin arbitration in IDLE, one ALU evaluation in EXEC and
// a held valid/ready response to the winner in RESP.
// Optional grant counters are enabled with the macro ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             busy
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             rr_ptr_r;
    logic             owner_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [2:0]       op_f_r;
    logic [WIDTH-1:0] res_y_r;
    logic             res_zero_r;
    logic             rsp0_valid_r;
    logic             rsp1_valid_r;
    logic             busy_r;

    logic             grant_s;
    logic             win_s;
    logic             rsp_take_s;

    // Counter width must be usable whenever the statistics are compiled in.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    // Round-robin arbitration; only meaningful while idle.
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_s = 1'b1;
                win_s   = rr_ptr_r;
            end else if (req0_valid) begin
                grant_s = 1'b1;
                win_s   = 1'b0;
            end else if (req1_valid) begin
                grant_s = 1'b1;
                win_s   = 1'b1;
            end else begin
                grant_s = 1'b0;
                win_s   = 1'b0;
            end
        end else begin
            grant_s = 1'b0;
            win_s   = 1'b0;
        end
    end

    // The owner's response ready ends the response phase.
    always_comb begin
        if (owner_r) begin
            rsp_take_s = rsp1_ready;
        end else begin
            rsp_take_s = rsp0_ready;
        end
    end

    assign req0_ready = grant_s & ~win_s;
    assign req1_ready = grant_s & win_s;

    // Transaction sequencer: accept, evaluate once, hold the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            rr_ptr_r     <= 1'b0;
            owner_r      <= 1'b0;
            op_a_r       <= {WIDTH{1'b0}};
            op_b_r       <= {WIDTH{1'b0}};
            op_f_r       <= 3'b000;
            res_y_r      <= {WIDTH{1'b0}};
            res_zero_r   <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        op_a_r   <= win_s ? req1_a : req0_a;
                        op_b_r   <= win_s ? req1_b : req0_b;
                        op_f_r   <= win_s ? req1_f : req0_f;
                        owner_r  <= win_s;
                        rr_ptr_r <= ~win_s;
                        busy_r   <= 1'b1;
                        state_r  <= EXEC;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                EXEC: begin
                    res_y_r      <= alu_y;
                    res_zero_r   <= alu_zero;
                    rsp0_valid_r <= ~owner_r;
                    rsp1_valid_r <= owner_r;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (rsp_take_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r      <= RESP;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_r;
    logic [CNT_W-1:0] grant_cnt1_r;

    // Per-requester handshake counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_r <= {CNT_W{1'b0}};
            grant_cnt1_r <= {CNT_W{1'b0}};
        end else if (grant_s) begin
            if (win_s) begin
                grant_cnt1_r <= grant_cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                grant_cnt0_r <= grant_cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            grant_cnt0_r <= grant_cnt0_r;
            grant_cnt1_r <= grant_cnt1_r;
        end
    end

    assign grant_cnt0 = grant_cnt0_r;
    assign grant_cnt1 = grant_cnt1_r;
`endif

    // ALU operands come only from the latched registers.
    assign alu_a      = op_a_r;
    assign alu_b      = op_b_r;
    assign alu_f      = op_f_r;

    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_y     = res_y_r;
    assign rsp1_y     = res_y_r;
    assign rsp0_zero  = res_zero_r;
    assign rsp1_zero  = res_zero_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;

`ifdef ALU_SHARE_ARBITER_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic [2:0]  req0_f = 3'd0, req1_f = 3'd0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_y, rsp1_y;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;
    logic        alu_zero;
    logic        busy;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    int vectors = 0;
    int miscompares = 0;
    int ptr = 0;          // model: who wins a contested arbitration
    int g0 = 0, g1 = 0;   // model: grants since last reset

    alu_share_arbiter #(.WIDTH(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_y(rsp0_y), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_y(rsp1_y), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .busy(busy)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Reference 3-bit-function ALU.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return a & ~b;
            3'b101:  return a | ~b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_y    = alu_fn(alu_a, alu_b, alu_f);
    assign alu_zero = (alu_y == 32'd0);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction from the currently driven requests; the caller has
    // set up the request signals at a negedge with at least one valid high.
    task automatic do_txn(input int hold, output logic [31:0] y_out);
        int          w;
        logic [31:0] a, b, ey;
        logic [2:0]  f;
        #1;
        if (req0_valid && req1_valid) w = ptr;
        else if (req1_valid)          w = 1;
        else                          w = 0;
        a  = w ? req1_a : req0_a;
        b  = w ? req1_b : req0_b;
        f  = w ? req1_f : req0_f;
        ey = alu_fn(a, b, f);
        check("idle_ready0", req0_ready, w == 0);
        check("idle_ready1", req1_ready, w == 1);
        check("idle_busy", busy, 1'b0);
        @(posedge clk);
        ptr = 1 - w;
        if (w == 1) g1++; else g0++;
        @(negedge clk);
        if (w == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
        #1;
        check("exec_busy", busy, 1'b1);
        check("exec_ready", {req0_ready, req1_ready}, 2'b00);
        check("exec_rspv", {rsp0_valid, rsp1_valid}, 2'b00);
        check("exec_alu", {alu_a, alu_b, 29'd0, alu_f}, {a, b, 29'd0, f});
        @(posedge clk);
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            check("resp_valid", {rsp0_valid, rsp1_valid}, (w == 1) ? 2'b01 : 2'b10);
            check("resp_y", w ? rsp1_y : rsp0_y, ey);
            check("resp_zero", w ? rsp1_zero : rsp0_zero, ey == 32'd0);
            check("resp_busy_noready", {busy, req0_ready, req1_ready}, 3'b100);
            if (i == hold) begin
                if (w == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("done_rspv", {rsp0_valid, rsp1_valid}, 2'b00);
        check("done_busy", busy, 1'b0);
        y_out = ey;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ptr = 0; g0 = 0; g1 = 0;
    endtask

    initial begin : main
        logic [31:0] y;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rspv", {rsp0_valid, rsp1_valid}, 2'b00);
        check("rst_alu", {alu_a, alu_b, 29'd0, alu_f}, 64'd0);
        check("rst_res", {rsp0_y, 31'd0, rsp0_zero}, 64'd0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);

        // Single requester 0: 5 + 7
        req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h7; req0_f = 3'b010;
        do_txn(0, y);
        check("add_const", y, 32'h0000000C);

        // Contention after reset: req0 first, then req1
        do_reset();
        req0_valid = 1'b1; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00; req0_f = 3'b000;
        req1_valid = 1'b1; req1_a = 32'h1; req1_b = 32'h2; req1_f = 3'b001;
        do_txn(0, y);
        check("cont_and", y, 32'hF000F000);
        do_txn(0, y);
        check("cont_or", y, 32'h00000003);

        // Zero flag through requester 1
        req1_valid = 1'b1; req1_a = 32'h12345678; req1_b = 32'h12345678; req1_f = 3'b110;
        do_txn(0, y);
        check("sub_zero", y, 32'h0);

        // Backpressure on rsp0 with req1 waiting; req1 then wins next
        req0_valid = 1'b1; req0_a = 32'h9; req0_b = 32'h3; req0_f = 3'b110;
        req1_valid = 1'b1; req1_a = 32'hA; req1_b = 32'h5; req1_f = 3'b111;
        do_txn(5, y);
        check("bp_sub", y, 32'h6);
        do_txn(0, y);

        // Reset while in EXEC aborts the transaction
        req0_valid = 1'b1; req0_a = 32'hDEAD; req0_b = 32'hBEEF; req0_f = 3'b011;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ptr = 0; g0 = 0; g1 = 0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_alu_a", alu_a, 32'd0);
        check("abort_alu_f", alu_f, 3'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_rspv", {rsp0_valid, rsp1_valid}, 2'b00);
        end
        req1_valid = 1'b1; req1_a = 32'h40; req1_b = 32'h2; req1_f = 3'b101;
        do_txn(1, y);

        // Randomized traffic; a loser keeps its request pending
        for (int n = 0; n < 60; n++) begin
            if (!req0_valid && ($urandom_range(0, 1) == 1)) begin
                req0_valid = 1'b1; req0_a = $urandom; req0_f = 3'($urandom_range(0, 7));
                req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            end
            if (!req1_valid && ($urandom_range(0, 1) == 1)) begin
                req1_valid = 1'b1; req1_a = $urandom; req1_f = 3'($urandom_range(0, 7));
                req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            end
            if (!req0_valid && !req1_valid) begin
                @(posedge clk);
                @(negedge clk);
                #1;
                check("idle_noreq", {busy, req0_ready, req1_ready}, 3'b000);
            end else begin
                do_txn($urandom_range(0, 3), y);
            end
        end

        // Five uncontested grants to req0
        do_reset();
        req1_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req0_valid = 1'b1; req0_a = 32'(k); req0_b = 32'd1; req0_f = 3'b010;
            do_txn(0, y);
        end
`ifdef ALU_SHARE_ARBITER_STATS_EN
        check("cnt0", grant_cnt0, CNT_W'(g0));
        check("cnt1", grant_cnt1, CNT_W'(g1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
